// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port data RAM.
// One access in flight; RAM control driven for exactly one cycle per access.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned BE_W   = DATA_W / 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [BE_W-1:0]   a_be,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [BE_W-1:0]   b_be,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_ack,
  output logic              b_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [BE_W-1:0]   ram_byteena,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t              r_state, w_next;
  logic                r_last_b, r_sel_b;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_a_gnt, r_b_gnt, r_a_ack, r_b_ack;
  logic [DATA_W-1:0]   r_a_rdata, r_b_rdata;
  logic                w_accept, w_win_b, w_done, w_issue, w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_win_b  = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_accept = 1'b1;
          // B wins when alone, or when contested and A won last time
          w_win_b  = b_req && (!a_req || !r_last_b);
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_done = r_we;
        w_next = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (w_cnt_last) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_b  <= 1'b1;
      r_sel_b   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_cnt     <= '0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_gnt <= w_accept && !w_win_b;
      r_b_gnt <= w_accept && w_win_b;
      r_a_ack <= w_done && !r_sel_b;
      r_b_ack <= w_done && r_sel_b;
      if (w_accept) begin
        r_sel_b  <= w_win_b;
        r_last_b <= w_win_b;
        r_we     <= w_win_b ? b_we    : a_we;
        r_addr   <= w_win_b ? b_addr  : a_addr;
        r_wdata  <= w_win_b ? b_wdata : a_wdata;
        r_be     <= w_win_b ? b_be    : a_be;
      end
      if (r_state == S_ISSUE && !r_we) r_cnt <= CNT_W'(RD_LAT);
      else if (r_state == S_WAIT)      r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == S_WAIT && w_cnt_last) begin
        if (r_sel_b) r_b_rdata <= ram_q;
        else         r_a_rdata <= ram_q;
      end
    end
  end

  // Address/data come straight from the latch, which only changes on accept,
  // so they naturally hold their last values outside ISSUE.
  assign w_issue     = (r_state == S_ISSUE);
  assign ram_address = r_addr;
  assign ram_data    = r_wdata;
  assign ram_wren    = w_issue && r_we;
  assign ram_byteena = (w_issue && r_we) ? r_be : '0;

  assign a_gnt   = r_a_gnt;
  assign b_gnt   = r_b_gnt;
  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: RD_LAT=1 instance with a byte-lane RAM model
// and an RD_LAT=2 instance with a two-stage read pipeline.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [17:0] a_addr = '0, b_addr = '0;
  logic [23:0] a_wdata = '0, b_wdata = '0;
  logic [2:0]  a_be = '0, b_be = '0;
  logic        a_gnt, b_gnt, a_ack, b_ack;
  logic [23:0] a_rdata, b_rdata;
  logic [17:0] ram_address;
  logic [23:0] ram_data, ram_q;
  logic        ram_wren;
  logic [2:0]  ram_byteena;

  logic        a2_req = 0, a2_we = 0, b2_req = 0, b2_we = 0;
  logic [17:0] a2_addr = '0, b2_addr = '0;
  logic [23:0] a2_wdata = '0, b2_wdata = '0;
  logic [2:0]  a2_be = '0, b2_be = '0;
  logic        a2_gnt, b2_gnt, a2_ack, b2_ack;
  logic [23:0] a2_rdata, b2_rdata;
  logic [17:0] ram2_address;
  logic [23:0] ram2_data, ram2_q, ram2_q0;
  logic        ram2_wren;
  logic [2:0]  ram2_byteena;

  int unsigned n_chk = 0, n_fail = 0;

  logic [23:0] mem1 [16];
  logic [23:0] mem2 [16];

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(18), .DATA_W(24), .RD_LAT(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ack(a_ack), .b_ack(b_ack),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_byteena(ram_byteena), .ram_q(ram_q)
  );

  ram_arbiter #(.ADDR_W(18), .DATA_W(24), .RD_LAT(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n),
    .a_req(a2_req), .a_we(a2_we), .a_addr(a2_addr), .a_wdata(a2_wdata), .a_be(a2_be),
    .b_req(b2_req), .b_we(b2_we), .b_addr(b2_addr), .b_wdata(b2_wdata), .b_be(b2_be),
    .a_gnt(a2_gnt), .b_gnt(b2_gnt), .a_ack(a2_ack), .b_ack(b2_ack),
    .a_rdata(a2_rdata), .b_rdata(b2_rdata),
    .ram_address(ram2_address), .ram_data(ram2_data), .ram_wren(ram2_wren),
    .ram_byteena(ram2_byteena), .ram_q(ram2_q)
  );

  // Single-port RAM models, read-before-write, small footprint on addr[3:0]
  always @(posedge clock) begin
    if (ram_wren) begin
      for (int unsigned l = 0; l < 3; l++)
        if (ram_byteena[l]) mem1[ram_address[3:0]][8*l +: 8] <= ram_data[8*l +: 8];
    end
    ram_q <= mem1[ram_address[3:0]];
  end

  always @(posedge clock) begin
    ram2_q0 <= mem2[ram2_address[3:0]];
    ram2_q  <= ram2_q0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic access(input bit port_b, input bit we, input logic [17:0] addr,
                        input logic [23:0] wd, input logic [2:0] be,
                        output logic [23:0] rd);
    bit got;
    if (port_b) begin
      b_we = we; b_addr = addr; b_wdata = wd; b_be = be; b_req = 1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wd; a_be = be; a_req = 1;
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (port_b ? b_gnt : a_gnt) got = 1;
    end
    a_req = 0; b_req = 0;
    chk("gnt_seen", {31'b0, got}, 32'd1);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (port_b ? b_ack : a_ack) got = 1;
    end
    chk("ack_seen", {31'b0, got}, 32'd1);
    rd = port_b ? b_rdata : a_rdata;
    step();
  endtask

  initial begin
    logic [23:0] rd;
    logic [3:0]  order;
    int          gcyc [4];
    int unsigned ng;

    for (int i = 0; i < 16; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    mem2[5] = 24'h5A5A5A;
    mem2[4] = 24'h111111;

    // Reset state
    #23;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_be", ram_byteena, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    step();
    reset_n = 1;

    // Single write on A
    a_req = 1; a_we = 1; a_addr = 18'h00001; a_wdata = 24'hFF0000; a_be = 3'b100;
    step();
    chk("w_a_gnt", a_gnt, 1);
    chk("w_b_gnt", b_gnt, 0);
    chk("w_wren", ram_wren, 1);
    chk("w_be", ram_byteena, 3'b100);
    chk("w_addr", ram_address, 18'h00001);
    chk("w_data", ram_data, 24'hFF0000);
    a_req = 0;
    step();
    chk("w_gnt_drop", a_gnt, 0);
    chk("w_ack", a_ack, 1);
    chk("w_wren_off", ram_wren, 0);
    chk("w_addr_hold", ram_address, 18'h00001);
    step();
    chk("w_ack_drop", a_ack, 0);

    // Read-back on B
    b_req = 1; b_we = 0; b_addr = 18'h00001;
    step();
    chk("r_b_gnt", b_gnt, 1);
    chk("r_wren", ram_wren, 0);
    chk("r_be", ram_byteena, 0);
    b_req = 0;
    step();
    chk("r_ack_early", b_ack, 0);
    step();
    chk("r_b_ack", b_ack, 1);
    chk("r_b_rdata", b_rdata, 24'hFF0000);
    chk("r_a_rdata", a_rdata, 0);
    step();
    chk("r_ack_drop", b_ack, 0);

    // Byte lanes
    access(0, 1, 18'h00004, 24'hABCDEF, 3'b111, rd);
    access(1, 1, 18'h00004, 24'h123456, 3'b010, rd);
    chk("wr_keeps_a_rdata", a_rdata, 0);
    chk("wr_keeps_b_rdata", b_rdata, 24'hFF0000);
    access(0, 0, 18'h00004, '0, '0, rd);
    chk("lane_merge", rd, 24'hAB34EF);
    chk("rd_keeps_other", b_rdata, 24'hFF0000);
    access(1, 1, 18'h00004, 24'h000000, 3'b000, rd);
    access(1, 0, 18'h00004, '0, '0, rd);
    chk("be0_unchanged", rd, 24'hAB34EF);

    // Contention from reset
    reset_n = 0;
    a_req = 1; a_we = 0; a_addr = 18'h00002;
    b_req = 1; b_we = 0; b_addr = 18'h00003;
    step();
    reset_n = 1;
    order = '0; ng = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("gnt_overlap", {31'b0, a_gnt & b_gnt}, 0);
      chk("ack_overlap", {31'b0, a_ack & b_ack}, 0);
      if ((a_gnt || b_gnt) && ng < 4) begin
        order[ng] = b_gnt;
        gcyc[ng] = c;
        ng++;
      end
    end
    a_req = 0; b_req = 0;
    chk("cont_count", ng, 4);
    chk("cont_order", order, 4'b1010);
    chk("cont_first", gcyc[0], 0);
    chk("cont_last", gcyc[3], 9);
    step(); step();

    // RD_LAT=2 instance
    a2_req = 1; a2_we = 0; a2_addr = 18'h00005;
    step();
    chk("l2_gnt", a2_gnt, 1);
    a2_req = 0;
    step();
    chk("l2_ack_e1", a2_ack, 0);
    step();
    chk("l2_ack_e2", a2_ack, 0);
    step();
    chk("l2_ack_e3", a2_ack, 1);
    chk("l2_rdata", a2_rdata, 24'h5A5A5A);
    step();

    // Reset during WAIT
    access(0, 0, 18'h00004, '0, '0, rd);
    chk("pre_rst_rdata", rd, 24'hAB34EF);
    a_req = 1; a_we = 0; a_addr = 18'h00004;
    step();
    chk("mr_gnt", a_gnt, 1);
    step();
    #2;
    reset_n = 0;
    #1;
    chk("mr_rdata", a_rdata, 0);
    chk("mr_ack", a_ack, 0);
    chk("mr_wren", ram_wren, 0);
    chk("mr_addr", ram_address, 0);
    step();
    chk("mr_no_ack", a_ack, 0);
    chk("mr_no_gnt", a_gnt, 0);
    reset_n = 1;
    step();
    chk("mr_fresh_gnt", a_gnt, 1);
    a_req = 0;
    step(); step(); step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
